// File: rtl/seq_arb_pkg.sv
// seq_arb_pkg: shared definitions for the sequencer arbiter.
//   - state_t     : arbiter FSM encoding (IDLE=0, LOAD=1, RUN=2, RELEASE=3)
//   - NW_DEFAULT  : default width of the job count field
//   - DW_DEFAULT  : default width of the job data word
//   - TIMEOUT_DEFAULT : default RUN watchdog length, used only when
//                       SEQ_ARB_TIMEOUT_EN is defined
package seq_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    RUN     = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam int NREQ_DEFAULT    = 4;
  localparam int NW_DEFAULT      = 8;
  localparam int DW_DEFAULT      = 32;
  localparam int TIMEOUT_DEFAULT = 1024;

endpackage

// File: rtl/seq_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector, shared with other arbiters.
// Ports:
//   req      in  NREQ  request levels
//   last     in  IW    index of the requester served most recently
//   gnt_next out NREQ  one-hot winner (zero when req is zero)
//   idx      out IW    index of the winner (zero when req is zero)
// The search starts at last+1 and wraps modulo NREQ, so the requester that
// was just served has the lowest priority.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic [NREQ-1:0] gnt_next,
  output logic [IW-1:0]   idx
);

  logic          found_s;
  logic [IW-1:0] cand_s;

  // Walk the requesters in priority order and keep the first one asserted.
  always_comb begin
    gnt_next = '0;
    idx      = '0;
    found_s  = 1'b0;
    cand_s   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand_s = IW'((int'(last) + k) % NREQ);
      if (!found_s && req[cand_s]) begin
        found_s          = 1'b1;
        gnt_next[cand_s] = 1'b1;
        idx              = cand_s;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/seq_arbiter.sv
// seq_arbiter: shares one byte sequencer between NREQ requesters.
// Requesters are granted round-robin; the granted job (count + word) is loaded
// into the sequencer, seq_en is held until seq_done, and a one-cycle done
// pulse is returned to the owner.
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   req     in  NREQ     per-requester request level (sampled in IDLE only)
//   req_n   in  NREQ*NW  packed counts, requester i at [i*NW +: NW]
//   req_in  in  NREQ*DW  packed words,  requester i at [i*DW +: DW]
//   gnt     out NREQ     one-hot owner of the sequencer
//   done    out NREQ     completion pulse to the owner
//   busy    out 1        high in every state except IDLE
//   seq_en  out 1        sequencer enable (high only in RUN)
//   seq_n   out NW       registered count to the sequencer
//   seq_in  out DW       registered word to the sequencer
//   seq_done in 1        sequencer completion, honoured in RUN only
//   err     out NREQ     (SEQ_ARB_TIMEOUT_EN only) timeout pulse to the owner
// Build option: define SEQ_ARB_TIMEOUT_EN to add the TIMEOUT parameter, the
// RUN watchdog and the err port.
module seq_arbiter
  import seq_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEFAULT,
  parameter int DW   = DW_DEFAULT,
  parameter int NW   = NW_DEFAULT
`ifdef SEQ_ARB_TIMEOUT_EN
  , parameter int TIMEOUT = TIMEOUT_DEFAULT
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*NW-1:0] req_n,
  input  logic [NREQ*DW-1:0] req_in,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic              busy,
  output logic              seq_en,
  output logic [NW-1:0]     seq_n,
  output logic [DW-1:0]     seq_in,
  input  logic              seq_done
`ifdef SEQ_ARB_TIMEOUT_EN
  , output logic [NREQ-1:0] err
`endif
);

  localparam int IW = $clog2(NREQ);

  state_t          state_r, state_next_s;
  logic [IW-1:0]   last_r, idx_r;
  logic [NREQ-1:0] gnt_r, done_r;
  logic            busy_r, seq_en_r;
  logic [NW-1:0]   seq_n_r;
  logic [DW-1:0]   seq_in_r;
  logic [NREQ-1:0] pick_gnt_s;
  logic [IW-1:0]   pick_idx_s;
  logic [NW-1:0]   cur_n_s;
  logic [DW-1:0]   cur_in_s;
  logic            run_timeout_s;

  rr_pick #(.NREQ(NREQ), .IW(IW)) u_rr_pick (
    .req      (req),
    .last     (last_r),
    .gnt_next (pick_gnt_s),
    .idx      (pick_idx_s)
  );

  // Operands of the current owner; only consumed in LOAD.
  assign cur_n_s  = req_n[idx_r*NW +: NW];
  assign cur_in_s = req_in[idx_r*DW +: DW];

`ifdef SEQ_ARB_TIMEOUT_EN
  logic [31:0]     cnt_r;
  logic [NREQ-1:0] err_r;

  // The watchdog fires on the last allowed RUN cycle unless the sequencer
  // completes in that same cycle (completion wins).
  assign run_timeout_s = (state_r == RUN) && !seq_done &&
                         (cnt_r == 32'(TIMEOUT - 1));
  assign err = err_r;
`else
  assign run_timeout_s = 1'b0;
`endif

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (|req) state_next_s = LOAD;
        else      state_next_s = IDLE;
      end
      LOAD: begin
        // A zero-length job skips the sequencer entirely.
        if (cur_n_s == '0) state_next_s = RELEASE;
        else               state_next_s = RUN;
      end
      RUN: begin
        if (seq_done || run_timeout_s) state_next_s = RELEASE;
        else                           state_next_s = RUN;
      end
      RELEASE: state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // State register and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      last_r   <= IW'(NREQ - 1);
      idx_r    <= '0;
      gnt_r    <= '0;
      done_r   <= '0;
      busy_r   <= 1'b0;
      seq_en_r <= 1'b0;
      seq_n_r  <= '0;
      seq_in_r <= '0;
`ifdef SEQ_ARB_TIMEOUT_EN
      cnt_r    <= 32'd0;
      err_r    <= '0;
`endif
    end else begin
      state_r  <= state_next_s;
      busy_r   <= (state_next_s != IDLE);
      // seq_en follows RUN exactly, so RELEASE always gives a one-cycle gap.
      seq_en_r <= (state_next_s == RUN);
      done_r   <= '0;
`ifdef SEQ_ARB_TIMEOUT_EN
      err_r    <= '0;
`endif
      case (state_r)
        IDLE: begin
          if (|req) begin
            gnt_r <= pick_gnt_s;
            idx_r <= pick_idx_s;
          end
        end
        LOAD: begin
          seq_n_r  <= cur_n_s;
          seq_in_r <= cur_in_s;
          if (cur_n_s == '0) done_r <= gnt_r;
`ifdef SEQ_ARB_TIMEOUT_EN
          cnt_r    <= 32'd0;
`endif
        end
        RUN: begin
          if (seq_done) done_r <= gnt_r;
`ifdef SEQ_ARB_TIMEOUT_EN
          else if (run_timeout_s) err_r <= gnt_r;
          cnt_r <= cnt_r + 32'd1;
`endif
        end
        RELEASE: begin
          gnt_r  <= '0;
          last_r <= idx_r;
        end
        default: begin
          gnt_r <= '0;
        end
      endcase
    end
  end

  assign gnt    = gnt_r;
  assign done   = done_r;
  assign busy   = busy_r;
  assign seq_en = seq_en_r;
  assign seq_n  = seq_n_r;
  assign seq_in = seq_in_r;

endmodule
